// File: rtl/ip_ascii8_mapper_pkg.sv
// Shared definitions for the ASCII8 ROM mapper: FSM encoding, window bounds, bank-select prefix.
// Optional bank masking is selected with the ASCII8_BANK_MASK_EN macro.
package ip_ascii8_mapper_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] WINDOW_LO       = 16'h4000;
    localparam logic [15:0] WINDOW_HI       = 16'hBFFF;
    localparam logic [4:0]  BANK_SEL_PREFIX = 5'b01100;

    function automatic logic in_window(input logic [15:0] addr);
        return (addr >= WINDOW_LO) && (addr <= WINDOW_HI);
    endfunction

    // 4000/6000/8000/A000 -> pages 0..3
    function automatic logic [1:0] page_of(input logic [1:0] addr_14_13);
        return addr_14_13 - 2'd2;
    endfunction

endpackage

// File: rtl/ip_ascii8_bank_regs.sv
// Four ASCII8 bank registers with write decode (6000-7FFF) and read-page decode.
// With ASCII8_BANK_MASK_EN defined, stored bank numbers are ANDed with ROM_BANK_MASK.
module ip_ascii8_bank_regs
    import ip_ascii8_mapper_pkg::*;
#(
    parameter logic [7:0] ROM_BANK_MASK = 8'hFF
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       wr_strobe,
    input  logic [4:0] addr_hi,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_bank
);

    logic [7:0] bank_reg [4];
    logic [3:0] bank_we;
    logic [7:0] bank_wdata;
    logic       wr_sel;

    // Bank writes live at 6000-7FFF; bits [12:11] pick the register
    assign wr_sel = wr_strobe && (addr_hi[4:2] == BANK_SEL_PREFIX[4:2]);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_we
            assign bank_we[gi] = wr_sel && (addr_hi[1:0] == 2'(gi));
        end
    endgenerate

`ifdef ASCII8_BANK_MASK_EN
    assign bank_wdata = wr_data & ROM_BANK_MASK;
`else
    logic [7:0] unused_bank_mask;
    assign unused_bank_mask = ROM_BANK_MASK;
    assign bank_wdata       = wr_data;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < 4; i++) begin
                bank_reg[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bank_we[i]) begin
                    bank_reg[i] <= bank_wdata;
                end
            end
        end
    end

    // Registered banks give the pre-write value to a read in the same cycle
    assign rd_bank = bank_reg[page_of(addr_hi[3:2])];

endmodule

// File: rtl/ip_ascii8_mapper.sv
// ASCII8 MSX ROM mapper: bank registers plus a read FSM fetching ROM bytes from a memory controller.
// Define ASCII8_BANK_MASK_EN to mask stored bank numbers with ROM_BANK_MASK.
module ip_ascii8_mapper
    import ip_ascii8_mapper_pkg::*;
#(
    parameter logic [7:0] ROM_BANK_MASK = 8'hFF
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] bus_address,
    input  logic        bus_read,
    input  logic        bus_write,
    input  logic [7:0]  bus_write_data,
    input  logic        bus_memory,
    output logic        bus_memory_cs,
    output logic        bus_read_ready,
    output logic [7:0]  bus_read_data,
    output logic [20:0] mem_address,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata
);

    state_t      state_reg;
    logic [20:0] mem_address_reg;
    logic        mem_req_reg;
    logic        ready_reg;
    logic [7:0]  data_reg;
    logic [7:0]  rd_bank;
    logic        rd_go;

    assign bus_memory_cs = in_window(bus_address);
    assign rd_go         = bus_read && bus_memory;

    ip_ascii8_bank_regs #(
        .ROM_BANK_MASK(ROM_BANK_MASK)
    ) u_bank_regs (
        .clk      (clk),
        .n_reset  (n_reset),
        .wr_strobe(bus_write && bus_memory),
        .addr_hi  (bus_address[15:11]),
        .wr_data  (bus_write_data),
        .rd_bank  (rd_bank)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg       <= IDLE;
            mem_address_reg <= 21'h0;
            mem_req_reg     <= 1'b0;
            ready_reg       <= 1'b0;
            data_reg        <= 8'h00;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (rd_go) begin
                        state_reg       <= REQ;
                        mem_address_reg <= {rd_bank, bus_address[12:0]};
                        mem_req_reg     <= 1'b1;
                        ready_reg       <= 1'b0;
                    end
                end
                REQ: begin
                    // New reads and bank writes leave the in-flight address alone
                    if (mem_ack) begin
                        state_reg   <= DONE;
                        data_reg    <= mem_rdata;
                        mem_req_reg <= 1'b0;
                        ready_reg   <= 1'b1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    mem_req_reg <= 1'b0;
                    ready_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_address    = mem_address_reg;
    assign mem_req        = mem_req_reg;
    assign bus_read_ready = ready_reg;
    assign bus_read_data  = data_reg;

endmodule

// File: tb/tb_ip_ascii8_mapper.sv
// Directed, table-driven bench for ip_ascii8_mapper (expected values differ when ASCII8_BANK_MASK_EN is defined).
module tb_ip_ascii8_mapper;

    logic        clk;
    logic        n_reset;
    logic [15:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [7:0]  bus_write_data;
    logic        bus_memory;
    logic        bus_memory_cs;
    logic        bus_read_ready;
    logic [7:0]  bus_read_data;
    logic [20:0] mem_address;
    logic        mem_req;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    ip_ascii8_mapper #(
        .ROM_BANK_MASK(8'h0F)
    ) dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .bus_address   (bus_address),
        .bus_read      (bus_read),
        .bus_write     (bus_write),
        .bus_write_data(bus_write_data),
        .bus_memory    (bus_memory),
        .bus_memory_cs (bus_memory_cs),
        .bus_read_ready(bus_read_ready),
        .bus_read_data (bus_read_data),
        .mem_address   (mem_address),
        .mem_req       (mem_req),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          wait_n;
        logic [7:0]  rdata;
        logic [20:0] exp_maddr;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        bit          cs;
    } cs_vec_t;

    vec_t    vecs [11];
    cs_vec_t cs_vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] wdata, input bit exp_cs);
        @(negedge clk);
        bus_address    = addr;
        bus_write_data = wdata;
        bus_write      = 1'b1;
        bus_memory     = 1'b1;
        #1;
        chk("write_cs", 32'(bus_memory_cs), 32'(exp_cs));
        @(negedge clk);
        bus_write  = 1'b0;
        bus_memory = 1'b0;
        chk("write_no_req", 32'(mem_req), 32'd0);
        $display("write %h <= %h", addr, wdata);
    endtask

    // Read with optional simultaneous bank write; ack arrives wait_n clocks after mem_req rises
    task automatic do_read(input logic [15:0] addr, input bit wr, input logic [7:0] wdata,
                           input int wait_n, input logic [7:0] rdata, input logic [20:0] exp_maddr);
        int lat;
        int first_ready;
        lat         = 0;
        first_ready = 0;
        @(negedge clk);
        bus_address    = addr;
        bus_read       = 1'b1;
        bus_memory     = 1'b1;
        bus_write      = wr;
        bus_write_data = wdata;
        @(negedge clk);
        lat        = 1;
        bus_read   = 1'b0;
        bus_write  = 1'b0;
        bus_memory = 1'b0;
        chk("read_maddr", 32'(mem_address), 32'(exp_maddr));
        chk("read_req_set", 32'(mem_req), 32'd1);
        if (bus_read_ready && first_ready == 0) first_ready = lat;
        for (int i = 1; i < wait_n; i++) begin
            @(negedge clk);
            lat++;
            if (bus_read_ready && first_ready == 0) first_ready = lat;
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        lat++;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        if (bus_read_ready && first_ready == 0) first_ready = lat;
        chk("read_latency", 32'(first_ready), 32'(1 + wait_n));
        chk("read_data", 32'(bus_read_data), 32'(rdata));
        chk("read_req_clr", 32'(mem_req), 32'd0);
        $display("read %h -> mem_address %h data %h ready after %0d clocks",
                 addr, mem_address, bus_read_data, first_ready);
    endtask

`ifdef ASCII8_BANK_MASK_EN
    localparam bit MASKED = 1'b1;
`else
    localparam bit MASKED = 1'b0;
`endif

    initial begin
        n_reset        = 1'b0;
        bus_address    = 16'h0;
        bus_read       = 1'b0;
        bus_write      = 1'b0;
        bus_write_data = 8'h0;
        bus_memory     = 1'b0;
        mem_ack        = 1'b0;
        mem_rdata      = 8'h0;

        vecs[0]  = '{1'b0, 16'h4000, 8'h00, 3, 8'h5A, 21'h000000};
        vecs[1]  = '{1'b1, 16'h6800, 8'h07, 0, 8'h00, 21'h000000};
        vecs[2]  = '{1'b0, 16'h7FFF, 8'h00, 1, 8'hC3, 21'h00FFFF};
        vecs[3]  = '{1'b1, 16'h7000, 8'h13, 0, 8'h00, 21'h000000};
        vecs[4]  = '{1'b0, 16'h8000, 8'h00, 2, 8'h11, MASKED ? 21'h006000 : 21'h026000};
        vecs[5]  = '{1'b1, 16'h7800, 8'hFF, 0, 8'h00, 21'h000000};
        vecs[6]  = '{1'b0, 16'hA123, 8'h00, 1, 8'h99, MASKED ? 21'h01E123 : 21'h1FE123};
        vecs[7]  = '{1'b1, 16'h5000, 8'hAA, 0, 8'h00, 21'h000000};
        vecs[8]  = '{1'b0, 16'h5FFF, 8'h00, 2, 8'h3C, 21'h001FFF};
        vecs[9]  = '{1'b1, 16'h9000, 8'h55, 0, 8'h00, 21'h000000};
        vecs[10] = '{1'b0, 16'h9000, 8'h00, 1, 8'h77, MASKED ? 21'h007000 : 21'h027000};

        cs_vecs[0] = '{16'h0000, 1'b0};
        cs_vecs[1] = '{16'h3FFF, 1'b0};
        cs_vecs[2] = '{16'h4000, 1'b1};
        cs_vecs[3] = '{16'h7FFF, 1'b1};
        cs_vecs[4] = '{16'h8000, 1'b1};
        cs_vecs[5] = '{16'hBFFF, 1'b1};
        cs_vecs[6] = '{16'hC000, 1'b0};
        cs_vecs[7] = '{16'hFFFF, 1'b0};

        // Reset state
        #12;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_ready", 32'(bus_read_ready), 32'd0);
        chk("rst_data", 32'(bus_read_data), 32'd0);
        chk("rst_maddr", 32'(mem_address), 32'd0);
        @(negedge clk);
        n_reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus_address = cs_vecs[i].addr;
            #1;
            chk("window_cs", 32'(bus_memory_cs), 32'(cs_vecs[i].cs));
            $display("cs %h -> %0d", cs_vecs[i].addr, bus_memory_cs);
        end

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].wdata, 1'b1);
            end else begin
                do_read(vecs[i].addr, 1'b0, 8'h00, vecs[i].wait_n, vecs[i].rdata, vecs[i].exp_maddr);
            end
        end

        // Ready stays up in DONE while idle
        repeat (3) @(negedge clk);
        chk("done_hold_ready", 32'(bus_read_ready), 32'd1);
        chk("done_hold_data", 32'(bus_read_data), 32'h77);

        // Same-cycle bank write and read: read sees old bank1 (07), next read the new one
        do_read(16'h6800, 1'b1, 8'h21, 1, 8'hA5, 21'h00E800);
        do_read(16'h6800, 1'b0, 8'h00, 1, 8'hA6, MASKED ? 21'h002800 : 21'h042800);

        // Bank write and a stray read during REQ must not disturb the in-flight request
        @(negedge clk);
        bus_address = 16'h6000;
        bus_read    = 1'b1;
        bus_memory  = 1'b1;
        @(negedge clk);
        chk("inflight_maddr", 32'(mem_address), MASKED ? 32'h002000 : 32'h042000);
        bus_address    = 16'h6800;
        bus_write      = 1'b1;
        bus_write_data = 8'h05;
        @(negedge clk);
        bus_read   = 1'b0;
        bus_write  = 1'b0;
        bus_memory = 1'b0;
        chk("inflight_keep", 32'(mem_address), MASKED ? 32'h002000 : 32'h042000);
        chk("inflight_req", 32'(mem_req), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 8'h66;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("inflight_data", 32'(bus_read_data), 32'h66);
        $display("in-flight read 6000 -> data %h", bus_read_data);
        do_read(16'h6000, 1'b0, 8'h00, 1, 8'h67, 21'h00A000);

        // Reset during REQ, then a late ack
        @(negedge clk);
        bus_address = 16'hA010;
        bus_read    = 1'b1;
        bus_memory  = 1'b1;
        @(negedge clk);
        bus_read   = 1'b0;
        bus_memory = 1'b0;
        chk("pre_reset_req", 32'(mem_req), 32'd1);
        n_reset = 1'b0;
        #1;
        chk("async_rst_req", 32'(mem_req), 32'd0);
        chk("async_rst_maddr", 32'(mem_address), 32'd0);
        chk("async_rst_ready", 32'(bus_read_ready), 32'd0);
        chk("async_rst_data", 32'(bus_read_data), 32'd0);
        @(negedge clk);
        n_reset   = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 8'hEE;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        @(negedge clk);
        chk("late_ack_req", 32'(mem_req), 32'd0);
        chk("late_ack_ready", 32'(bus_read_ready), 32'd0);
        chk("late_ack_data", 32'(bus_read_data), 32'd0);
        $display("reset in REQ, late ack -> ready %0d data %h", bus_read_ready, bus_read_data);
        do_read(16'hA010, 1'b0, 8'h00, 2, 8'h42, 21'h000010);

        // Outside the window: no request; write to 5000 leaves banks alone
        @(negedge clk);
        bus_address = 16'hC000;
        bus_read    = 1'b1;
        bus_memory  = 1'b0;
        #1;
        chk("c000_cs", 32'(bus_memory_cs), 32'd0);
        @(negedge clk);
        bus_read = 1'b0;
        repeat (2) @(negedge clk);
        chk("c000_no_req", 32'(mem_req), 32'd0);
        $display("read C000 -> cs 0, mem_req %0d", mem_req);
        do_write(16'h5000, 8'h44, 1'b1);
        do_read(16'h8000, 1'b0, 8'h00, 1, 8'h12, 21'h000000);
        do_read(16'h4000, 1'b0, 8'h00, 1, 8'h13, 21'h000000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ip_ascii8_mapper.md
IP_ASCII8_MAPPER -- requirements
Module: ip_ascii8_mapper

Interface
REQ-001 The block SHALL have parameter ROM_BANK_MASK, default 8'hFF, the bank-number mask applied when ASCII8_BANK_MASK_EN is defined.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock, the only clock in the block.
REQ-003 The block SHALL have port n_reset, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port bus_address, input, 16 bits: latched MSX address from the bus-protocol stage.
REQ-005 The block SHALL have port bus_read, input, 1 bit: one-clock read strobe.
REQ-006 The block SHALL have port bus_write, input, 1 bit: one-clock write strobe.
REQ-007 The block SHALL have port bus_write_data, input, 8 bits: latched write data.
REQ-008 The block SHALL have port bus_memory, input, 1 bit: slot-selected memory cycle qualified by bus_memory_cs.
REQ-009 The block SHALL have port bus_memory_cs, output, 1 bit: the address falls in the mapper window.
REQ-010 The block SHALL have port bus_read_ready, output, 1 bit: bus_read_data is valid.
REQ-011 The block SHALL have port bus_read_data, output, 8 bits: ROM byte returned to the bus stage.
REQ-012 The block SHALL have port mem_address, output, 21 bits: ROM byte address.
REQ-013 The block SHALL have port mem_req, output, 1 bit: read request to the memory controller, held until acknowledged.
REQ-014 The block SHALL have port mem_ack, input, 1 bit: one-clock acknowledge; mem_rdata is valid in that cycle.
REQ-015 The block SHALL have port mem_rdata, input, 8 bits: memory read data.

Function
REQ-016 The block SHALL drive bus_memory_cs combinationally as 1 iff 16'h4000 <= bus_address <= 16'hBFFF.
REQ-017 The block SHALL hold four 8-bit bank registers; page p = bus_address[14:13]-2 maps 4000/6000/8000/A000 to banks 0..3.
REQ-018 On bus_write & bus_memory with bus_address[15:11] = 5'b01100/01101/01110/01111, the block SHALL load bank0/1/2/3 with bus_write_data on the next clock.
REQ-019 The block SHALL ignore writes outside 6000-7FFF; ROM writes SHALL never reach the memory port.
REQ-020 The FSM SHALL have states IDLE, REQ and DONE.
REQ-021 IDLE->REQ on bus_read & bus_memory; at that edge the block SHALL register mem_address = {bank[p], bus_address[12:0]}, set mem_req=1 and clear bus_read_ready.
REQ-022 REQ->DONE on mem_ack; at that edge the block SHALL capture bus_read_data=mem_rdata, set mem_req=0 and set bus_read_ready=1.
REQ-023 DONE->REQ on a new qualifying bus_read, with the same actions as IDLE->REQ; otherwise DONE SHALL hold and bus_read_ready SHALL stay 1.
REQ-024 In REQ, the block SHALL ignore bus_read; a bank write in REQ SHALL update the register but not the in-flight mem_address.
REQ-025 Latency from bus_read to bus_read_ready SHALL be 1 clock plus the mem_ack wait, with a minimum of 2 clocks.
REQ-026 If bank write and read occur in the same cycle, the read SHALL use the pre-write bank value.

Reset
REQ-027 n_reset low SHALL asynchronously force: FSM IDLE, all banks 8'h00, mem_req 0, mem_address 0, bus_read_ready 0, bus_read_data 8'h00.
REQ-028 Reset asserted while in REQ SHALL abandon the request; the block SHALL ignore a late mem_ack arriving in IDLE.

Configuration
REQ-029 With ASCII8_BANK_MASK_EN defined, the block SHALL store bank writes as bus_write_data & ROM_BANK_MASK, so banks wrap for small ROMs.
REQ-030 Without ASCII8_BANK_MASK_EN, the block SHALL store all 8 bits and SHALL leave ROM_BANK_MASK unused.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the window bounds 16'h4000/16'hBFFF and the bank-select prefix 5'b01100.
REQ-032 The block SHALL be single-module; a sub-module ip_ascii8_bank_regs (four registers plus page decode) is permitted.

Verification
REQ-033 Reset, then read 4000h with mem_ack after 3 clocks and rdata 5Ah -> mem_address 21'h000000; ready rises 4 clocks after bus_read; data 5Ah.
REQ-034 Write 07h to 6800h, then read 7FFFh -> mem_address {8'h07,13'h1FFF} = 21'h0FFFF.
REQ-035 With ASCII8_BANK_MASK_EN and mask 8'h0F, write 13h to 7000h, then read 8000h -> bank 03h, mem_address 21'h06000.
REQ-036 Bank write to 6000h in the same cycle as a read of 4000h -> the read uses the old bank; the following read uses the new bank.
REQ-037 Assert n_reset while in REQ, then pulse mem_ack -> mem_req 0, ready 0, FSM IDLE, data 00h, with no capture.
REQ-038 Read C000h and write 5000h -> bus_memory_cs 0 for C000h, no mem_req, and banks unchanged.
